// File: rtl/hamming_tx_sched.sv
// hamming_tx_sched: two-requester, byte-granular round-robin scheduler in
// front of one shared SECDED nibble encoder. Each byte goes out as two
// 8-bit codewords, low nibble first, through a single registered
// valid/ready output stage.
// Optional build macro: HAMMING_ERR_INJECT_EN adds inj_en/inj_pos, which flip
// one codeword bit as the word is loaded into the output register.

// Nibble to 8-bit SECDED codeword {p_all, d3, d2, d1, c2, d0, c1, c0}.
module hamming_encoder (
    input  logic [3:0] nibble,
    output logic [7:0] code
);
    logic c0, c1, c2;
    logic [6:0] hamming7;

    assign c0       = nibble[0] ^ nibble[1] ^ nibble[3];
    assign c1       = nibble[0] ^ nibble[2] ^ nibble[3];
    assign c2       = nibble[1] ^ nibble[2] ^ nibble[3];
    assign hamming7 = {nibble[3], nibble[2], nibble[1], c2, nibble[0], c1, c0};
    // The overall parity bit makes the complete word even.
    assign code     = {^hamming7, hamming7};
endmodule

module hamming_tx_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_0,
    input  logic [7:0] in_data_0,
    output logic       in_ready_0,
    input  logic       in_valid_1,
    input  logic [7:0] in_data_1,
    output logic       in_ready_1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_code,
    output logic       out_src,
    output logic       out_last
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic       inj_en,
    input  logic [2:0] inj_pos
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] buf_data;
    logic       buf_src;
    logic       rr_last;

    logic       can_load;
    logic       accept_ok;
    logic       grant_0;
    logic       grant_1;
    logic       accept;
    logic [7:0] acc_data;
    logic       load;
    logic [3:0] enc_nibble;
    logic [7:0] enc_code;
    logic [7:0] inj_mask;

    // Output slot is free, or it is being drained this cycle.
    assign can_load  = !out_valid || out_ready;

    // A new byte fits when the buffer is empty, or when its last nibble leaves now.
    assign accept_ok = (state == ST_IDLE) || ((state == ST_HI) && can_load);

    // Round-robin grant: a lone requester always wins; on contention the
    // requester that was not served last wins.
    assign grant_0    = in_valid_0 && (!in_valid_1 || rr_last);
    assign grant_1    = in_valid_1 && (!in_valid_0 || !rr_last);
    assign in_ready_0 = grant_0 && accept_ok;
    assign in_ready_1 = grant_1 && accept_ok;
    assign accept     = in_ready_0 || in_ready_1;
    assign acc_data   = in_ready_1 ? in_data_1 : in_data_0;

    // A codeword is produced whenever a nibble is pending and the slot is free.
    assign load       = can_load && ((state == ST_LO) || (state == ST_HI));
    assign enc_nibble = (state == ST_HI) ? buf_data[7:4] : buf_data[3:0];

    hamming_encoder u_enc (
        .nibble (enc_nibble),
        .code   (enc_code)
    );

`ifdef HAMMING_ERR_INJECT_EN
    // Single-bit error pattern applied only to words loaded while inj_en is high.
    assign inj_mask = inj_en ? (8'h01 << inj_pos) : 8'h00;
`else
    assign inj_mask = 8'h00;
`endif

    // Byte buffer FSM, round-robin pointer and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here, including the byte buffer, is reset so a
            // byte cut short by reset can never be emitted after release.
            state     <= ST_IDLE;
            buf_data  <= 8'h00;
            buf_src   <= 1'b0;
            rr_last   <= 1'b1;
            out_valid <= 1'b0;
            out_code  <= 8'h00;
            out_src   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every decision in this block uses
            // the state from before the clock edge.
            if (accept) begin
                buf_data <= acc_data;
                buf_src  <= in_ready_1;
                rr_last  <= in_ready_1;
            end

            if (load) begin
                out_valid <= 1'b1;
                out_code  <= enc_code ^ inj_mask;
                out_src   <= buf_src;
                out_last  <= (state == ST_HI);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: if (accept)   state <= ST_LO;
                ST_LO:   if (can_load) state <= ST_HI;
                ST_HI:   if (can_load) state <= accept ? ST_LO : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
